decode_queue: RTL and testbench

//  Buffered, registered RV32I decode stage between fetch and execute. Accepts

---
 rtl/decode_queue.sv | 208 ++++++++++++++++++++
 tb/tb_decode_queue.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// RV32I(+M) decode stage: DEPTH-entry fetch FIFO feeding a registered decode
// output with valid/ready handshake, load-use bubble insertion and flush.
package decode_queue_pkg;

  typedef struct packed {
    logic       illegal;
    logic       is_jalr;
    logic       is_muldiv;
    logic       is_load;
    logic       is_lui;
    logic       alu_src2;
    logic       alu_src1;
    logic       mem_to_reg;
    logic       mem_wen;
    logic       rd_wen;
    logic       arith;
    logic       is_unsigned;
    logic       sub;
    logic [2:0] opsel;
    logic [5:0] fmt;      // one-hot {J,U,B,S,I,R}
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;

endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter bit          ENABLE_M = 1'b0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_inst_valid,
  input  logic [31:0]              i_inst,
  input  logic [31:0]              i_pc,
  output logic                     o_inst_ready,
  output logic                     o_dec_valid,
  input  logic                     i_dec_ready,
  output logic [31:0]              o_pc,
  output logic [31:0]              o_inst,
  output logic [21:0]              o_ctrl,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_bubble,
  output logic [CNT_W-1:0]         o_bubble_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  // Pure decode of one instruction word into the control bundle.
  function automatic ctrl_t decode(input logic [31:0] inst);
    ctrl_t      c;
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       r, i, s, b, u, j, m_op, bad;
    op   = inst[6:0];
    f3   = inst[14:12];
    f7   = inst[31:25];
    c    = '0;
    r    = (op == OP_R);
    i    = (op == OP_IMM) | (op == OP_LOAD) | (op == OP_JALR) |
           (op == OP_FENCE) | (op == OP_SYS);
    s    = (op == OP_STORE);
    b    = (op == OP_BR);
    u    = (op == OP_LUI) | (op == OP_AUIPC);
    j    = (op == OP_JAL);
    m_op = ENABLE_M && r && (f7 == 7'b0000001);
    bad  = !(r | i | s | b | u | j) ||
           (r && (f7 != 7'b0000000) && (f7 != 7'b0100000) && !m_op);
    if (r) begin
      c.opsel       = f3;
      c.sub         = inst[30];
      c.arith       = inst[30];
      c.is_unsigned = inst[12];
    end
    if (op == OP_IMM) begin
      c.opsel       = f3;
      c.arith       = inst[30];
      c.is_unsigned = inst[12];
    end
    if (b) begin
      c.opsel       = (f3[2:1] == 2'b00) ? 3'b000 : 3'b011;
      c.sub         = 1'b1;
      c.is_unsigned = inst[13];
    end
    if (m_op) begin
      c.is_muldiv = 1'b1;
      c.sub       = 1'b0;
      c.arith     = 1'b0;
    end
    // Illegal words carry no format, so they read and write nothing.
    if (bad) {r, i, s, b, u, j} = 6'b0;
    c.fmt        = {j, u, b, s, i, r};
    c.is_load    = (op == OP_LOAD);
    c.is_jalr    = (op == OP_JALR);
    c.is_lui     = u & inst[5];
    c.alu_src1   = u;
    c.alu_src2   = r | b;
    c.mem_wen    = s;
    c.mem_to_reg = c.is_load;
    c.rd_wen     = !(s | b) && !bad;
    c.illegal    = bad;
    return c;
  endfunction

  fetch_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [OCC_W-1:0]   count_q, count_next;
  logic               ready_q, valid_q, bubble_q;
  logic [31:0]        pc_q, inst_q;
  ctrl_t              ctrl_q;
  logic [CNT_W-1:0]   bcnt_q;

  fetch_t             head;
  ctrl_t              head_ctrl;
  logic               empty, hazard, push, load, bubble_ev;
  logic               reads_rs1, reads_rs2;
  logic [4:0]         out_rd;

  // Head decode and load-use hazard against the instruction in the output stage.
  always_comb begin
    head      = mem[rd_ptr];
    head_ctrl = decode(head.inst);
    empty     = (count_q == '0);
    out_rd    = inst_q[11:7];
    reads_rs1 = |head_ctrl.fmt[3:0];
    reads_rs2 = head_ctrl.fmt[0] | head_ctrl.fmt[2] | head_ctrl.fmt[3];
    hazard    = valid_q && ctrl_q.is_load && (out_rd != 5'd0) && !empty &&
                ((reads_rs1 && (head.inst[19:15] == out_rd)) ||
                 (reads_rs2 && (head.inst[24:20] == out_rd)));
    push       = i_inst_valid && ready_q && !i_flush;
    load       = (!valid_q || i_dec_ready) && !empty && !hazard && !i_flush;
    bubble_ev  = hazard && i_dec_ready && !i_flush;
    count_next = count_q + OCC_W'(push) - OCC_W'(load);
  end

  // Storage array needs no reset; occupancy tracking guards reads.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= '{pc: i_pc, inst: i_inst};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      pc_q     <= '0;
      inst_q   <= '0;
      ctrl_q   <= '0;
      bubble_q <= 1'b0;
      bcnt_q   <= '0;
    end else if (i_flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      bubble_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (load) rd_ptr <= rd_ptr + PTR_W'(1);
      count_q  <= count_next;
      ready_q  <= (count_next != OCC_W'(DEPTH));
      bubble_q <= bubble_ev;
      if (bubble_ev && (bcnt_q != '1)) bcnt_q <= bcnt_q + CNT_W'(1);
      if (load) begin
        valid_q <= 1'b1;
        pc_q    <= head.pc;
        inst_q  <= head.inst;
        ctrl_q  <= head_ctrl;
      end else if (i_dec_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_inst_ready   = ready_q;
  assign o_dec_valid    = valid_q;
  assign o_pc           = pc_q;
  assign o_inst         = inst_q;
  assign o_ctrl         = ctrl_q;
  assign o_count        = count_q;
  assign o_bubble       = bubble_q;
  assign o_bubble_count = bcnt_q;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: two instances (ENABLE_M 0 and 1) share stimulus.
module tb_decode_queue;

  logic        clk = 1'b0;
  logic        rst_n, flush, inst_valid, dec_ready;
  logic [31:0] inst, pc;

  logic        d0_inst_ready, d0_dec_valid, d0_bubble;
  logic [31:0] d0_pc, d0_inst;
  logic [21:0] d0_ctrl;
  logic [2:0]  d0_count;
  logic [15:0] d0_bcnt;

  logic        d1_inst_ready, d1_dec_valid, d1_bubble;
  logic [31:0] d1_pc, d1_inst;
  logic [21:0] d1_ctrl;
  logic [2:0]  d1_count;
  logic [15:0] d1_bcnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(4), .ENABLE_M(1'b0), .CNT_W(16)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_inst_valid(inst_valid),
    .i_inst(inst), .i_pc(pc), .o_inst_ready(d0_inst_ready), .o_dec_valid(d0_dec_valid),
    .i_dec_ready(dec_ready), .o_pc(d0_pc), .o_inst(d0_inst), .o_ctrl(d0_ctrl),
    .o_count(d0_count), .o_bubble(d0_bubble), .o_bubble_count(d0_bcnt)
  );

  decode_queue #(.DEPTH(4), .ENABLE_M(1'b1), .CNT_W(16)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_inst_valid(inst_valid),
    .i_inst(inst), .i_pc(pc), .o_inst_ready(d1_inst_ready), .o_dec_valid(d1_dec_valid),
    .i_dec_ready(dec_ready), .o_pc(d1_pc), .o_inst(d1_inst), .o_ctrl(d1_ctrl),
    .o_count(d1_count), .o_bubble(d1_bubble), .o_bubble_count(d1_bcnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vec_inst [7];
  logic [31:0] vec_c0   [7];
  logic [31:0] vec_c1   [7];
  int          acc;

  initial begin
    rst_n = 1'b0; flush = 1'b0; inst_valid = 1'b0; dec_ready = 1'b0;
    inst = '0; pc = '0;
    // inst, expected ctrl with ENABLE_M=0, expected ctrl with ENABLE_M=1
    vec_inst[0] = 32'h002081B3; vec_c0[0] = 32'h00011001; vec_c1[0] = 32'h00011001; // add
    vec_inst[1] = 32'h403100B3; vec_c0[1] = 32'h00011A01; vec_c1[1] = 32'h00011A01; // sub
    vec_inst[2] = 32'h00208463; vec_c0[2] = 32'h00010208; vec_c1[2] = 32'h00010208; // beq
    vec_inst[3] = 32'h0020E463; vec_c0[3] = 32'h000106C8; vec_c1[3] = 32'h000106C8; // bltu
    vec_inst[4] = 32'h000010B7; vec_c0[4] = 32'h00029010; vec_c1[4] = 32'h00029010; // lui
    vec_inst[5] = 32'h0000A283; vec_c0[5] = 32'h00045002; vec_c1[5] = 32'h00045002; // lw
    vec_inst[6] = 32'h022081B3; vec_c0[6] = 32'h00200000; vec_c1[6] = 32'h00091001; // mul

    repeat (2) step();
    check("rst_valid", 32'(d0_dec_valid), 32'd0);
    check("rst_count", 32'(d0_count), 32'd0);
    check("rst_ready", 32'(d0_inst_ready), 32'd1);
    check("rst_ctrl", 32'(d0_ctrl), 32'd0);
    check("rst_bcnt", 32'(d0_bcnt), 32'd0);
    rst_n = 1'b1;
    step();

    // Single instructions: no bypass, valid two edges after offer, decode checked
    dec_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      inst_valid = 1'b1; inst = vec_inst[v]; pc = 32'h40 + 32'(v * 4);
      step();
      inst_valid = 1'b0;
      check("nobypass", 32'(d0_dec_valid), 32'd0);
      check("count1", 32'(d0_count), 32'd1);
      step();
      check("dec_valid", 32'(d0_dec_valid), 32'd1);
      check("ctrl_m0", 32'(d0_ctrl), vec_c0[v]);
      check("ctrl_m1", 32'(d1_ctrl), vec_c1[v]);
      check("dec_pc", d0_pc, 32'h40 + 32'(v * 4));
      check("dec_inst", d0_inst, vec_inst[v]);
      step();
      check("consumed", 32'(d0_dec_valid), 32'd0);
    end

    // Load-use: lw x5 then add x6,x5,x1 -> one bubble
    inst_valid = 1'b1; inst = 32'h0000A283; pc = 32'h100;
    step();
    inst = 32'h00128333; pc = 32'h104;
    step();
    inst_valid = 1'b0;
    check("lu_lw_valid", 32'(d0_dec_valid), 32'd1);
    check("lu_lw_pc", d0_pc, 32'h100);
    check("lu_no_bub", 32'(d0_bubble), 32'd0);
    step();
    check("lu_gap", 32'(d0_dec_valid), 32'd0);
    check("lu_bubble", 32'(d0_bubble), 32'd1);
    check("lu_bcnt", 32'(d0_bcnt), 32'd1);
    step();
    check("lu_add_valid", 32'(d0_dec_valid), 32'd1);
    check("lu_add_pc", d0_pc, 32'h104);
    check("lu_bub_clr", 32'(d0_bubble), 32'd0);
    step();

    // Independent add after lw: no bubble
    inst_valid = 1'b1; inst = 32'h0000A283; pc = 32'h108;
    step();
    inst = 32'h002083B3; pc = 32'h10C;
    step();
    inst_valid = 1'b0;
    check("ind_lw_pc", d0_pc, 32'h108);
    step();
    check("ind_valid", 32'(d0_dec_valid), 32'd1);
    check("ind_pc", d0_pc, 32'h10C);
    check("ind_bcnt", 32'(d0_bcnt), 32'd1);
    step();

    // Backpressure: 6 offered, 5 accepted, then in-order drain
    dec_ready = 1'b0; acc = 0;
    for (int k = 0; k < 6; k++) begin
      inst_valid = 1'b1; inst = 32'h002081B3; pc = 32'h200 + 32'(k * 4);
      if (d0_inst_ready) acc++;
      step();
    end
    inst_valid = 1'b0;
    check("bp_accepted", 32'(acc), 32'd5);
    check("bp_count", 32'(d0_count), 32'd4);
    check("bp_ready", 32'(d0_inst_ready), 32'd0);
    check("bp_pc", d0_pc, 32'h200);
    step();
    check("bp_hold_pc", d0_pc, 32'h200);
    check("bp_hold_valid", 32'(d0_dec_valid), 32'd1);
    dec_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      check("drain_valid", 32'(d0_dec_valid), 32'd1);
      check("drain_pc", d0_pc, 32'h200 + 32'(j * 4));
      step();
    end
    check("drain_empty", 32'(d0_dec_valid), 32'd0);
    check("drain_count", 32'(d0_count), 32'd0);

    // Flush with same-cycle enqueue
    dec_ready = 1'b0;
    inst_valid = 1'b1; inst = 32'h002081B3; pc = 32'h300;
    step();
    pc = 32'h304;
    step();
    check("fl_pre_count", 32'(d0_count), 32'd1);
    flush = 1'b1; pc = 32'h308;
    step();
    flush = 1'b0; inst_valid = 1'b0;
    check("fl_count", 32'(d0_count), 32'd0);
    check("fl_valid", 32'(d0_dec_valid), 32'd0);
    check("fl_ready", 32'(d0_inst_ready), 32'd1);
    check("fl_bcnt", 32'(d0_bcnt), 32'd1);
    dec_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("fl_none", 32'(d0_dec_valid), 32'd0);
    end

    // Asynchronous reset in the middle of traffic
    dec_ready = 1'b0;
    inst_valid = 1'b1; inst = 32'h002081B3; pc = 32'h400;
    step();
    step();
    step();
    rst_n = 1'b0;
    #2;
    check("arst_valid", 32'(d0_dec_valid), 32'd0);
    check("arst_count", 32'(d0_count), 32'd0);
    check("arst_ready", 32'(d0_inst_ready), 32'd1);
    check("arst_bcnt", 32'(d0_bcnt), 32'd0);
    inst_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
